// File: rtl/id_ex_stage_if.sv
// ID->EX stage bundle: decoded instruction in from the ID side, registered
// instruction plus hazard/monitor outputs back toward EX and the front end.
interface id_ex_stage_if #(
   parameter int XLEN         = 32,
   parameter int ALU_OP_WIDTH = 4,
   parameter int REG_ADDR_W   = 5,
   parameter int CNT_W        = 16
);
   logic                    id_valid_i;
   logic [XLEN-1:0]         id_pc_i;
   logic [XLEN-1:0]         id_rs1_data_i;
   logic [XLEN-1:0]         id_rs2_data_i;
   logic [XLEN-1:0]         id_imm_i;
   logic [REG_ADDR_W-1:0]   id_rs1_i;
   logic [REG_ADDR_W-1:0]   id_rs2_i;
   logic [REG_ADDR_W-1:0]   id_rd_i;
   logic [2:0]              id_funct3_i;
   logic                    id_uses_rs1_i;
   logic                    id_uses_rs2_i;
   logic                    RegWrite_i;
   logic                    MemToReg_i;
   logic                    MemRead_i;
   logic                    MemWrite_i;
   logic                    Branch_i;
   logic                    ALUSrc_i;
   logic [ALU_OP_WIDTH-1:0] ALUOp_i;
   logic                    flush_i;
   logic                    stall_i;

   logic                    ex_valid_o;
   logic [XLEN-1:0]         ex_pc_o;
   logic [XLEN-1:0]         ex_rs1_data_o;
   logic [XLEN-1:0]         ex_rs2_data_o;
   logic [XLEN-1:0]         ex_imm_o;
   logic [REG_ADDR_W-1:0]   ex_rs1_o;
   logic [REG_ADDR_W-1:0]   ex_rs2_o;
   logic [REG_ADDR_W-1:0]   ex_rd_o;
   logic [2:0]              ex_funct3_o;
   logic                    ex_RegWrite_o;
   logic                    ex_MemToReg_o;
   logic                    ex_MemRead_o;
   logic                    ex_MemWrite_o;
   logic                    ex_Branch_o;
   logic                    ex_ALUSrc_o;
   logic [ALU_OP_WIDTH-1:0] ex_ALUOp_o;
   logic                    hazard_stall_o;
   logic [CNT_W-1:0]        bubble_cnt_o;

   modport master (
      output id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
             id_rs1_i, id_rs2_i, id_rd_i, id_funct3_i, id_uses_rs1_i, id_uses_rs2_i,
             RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, Branch_i, ALUSrc_i,
             ALUOp_i, flush_i, stall_i,
      input  ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
             ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o, ex_RegWrite_o, ex_MemToReg_o,
             ex_MemRead_o, ex_MemWrite_o, ex_Branch_o, ex_ALUSrc_o, ex_ALUOp_o,
             hazard_stall_o, bubble_cnt_o
   );

   modport slave (
      input  id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
             id_rs1_i, id_rs2_i, id_rd_i, id_funct3_i, id_uses_rs1_i, id_uses_rs2_i,
             RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, Branch_i, ALUSrc_i,
             ALUOp_i, flush_i, stall_i,
      output ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
             ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o, ex_RegWrite_o, ex_MemToReg_o,
             ex_MemRead_o, ex_MemWrite_o, ex_Branch_o, ex_ALUSrc_o, ex_ALUOp_o,
             hazard_stall_o, bubble_cnt_o
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use hazard detection, flush/stall
// handling and a saturating counter of inserted load-use bubbles.
module id_ex_stage #(
   parameter int XLEN         = 32,
   parameter int ALU_OP_WIDTH = 4,
   parameter int REG_ADDR_W   = 5,
   parameter int CNT_W        = 16
) (
   input logic          clk,
   input logic          rst_n,
   id_ex_stage_if.slave bus
);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD = '0;

   typedef enum logic [1:0] {UPD_LOAD, UPD_HOLD, UPD_FLUSH, UPD_BUBBLE} upd_e;

   upd_e                    upd;
   logic                    rs1_match, rs2_match, hazard;

   logic                    ex_valid_q;
   logic [XLEN-1:0]         pc_q, rs1_data_q, rs2_data_q, imm_q;
   logic [REG_ADDR_W-1:0]   rs1_q, rs2_q, rd_q;
   logic [2:0]              funct3_q;
   logic                    reg_write_q, mem_to_reg_q, mem_read_q;
   logic                    mem_write_q, branch_q, alu_src_q;
   logic [ALU_OP_WIDTH-1:0] alu_op_q;
   logic [CNT_W-1:0]        bubble_cnt_q;

   always_comb begin
      rs1_match = bus.id_uses_rs1_i && (bus.id_rs1_i == rd_q);
      rs2_match = bus.id_uses_rs2_i && (bus.id_rs2_i == rd_q);
      hazard    = bus.id_valid_i && ex_valid_q && mem_read_q && (rd_q != '0) &&
                  (rs1_match || rs2_match);
      upd = UPD_LOAD;
      if (bus.flush_i)      upd = UPD_FLUSH;
      else if (bus.stall_i) upd = UPD_HOLD;
      else if (hazard)      upd = UPD_BUBBLE;
   end

   assign bus.hazard_stall_o = hazard && !bus.flush_i;

   // Datapath, indices and funct3 only move on a real load; bubbles keep them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         funct3_q   <= '0;
      end else if (upd == UPD_LOAD) begin
         pc_q       <= bus.id_pc_i;
         rs1_data_q <= bus.id_rs1_data_i;
         rs2_data_q <= bus.id_rs2_data_i;
         imm_q      <= bus.id_imm_i;
         rs1_q      <= bus.id_rs1_i;
         rs2_q      <= bus.id_rs2_i;
         rd_q       <= bus.id_rd_i;
         funct3_q   <= bus.id_funct3_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q   <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         branch_q     <= 1'b0;
         alu_src_q    <= 1'b0;
         alu_op_q     <= ALU_OP_ADD;
      end else begin
         case (upd)
            UPD_LOAD: begin
               ex_valid_q   <= bus.id_valid_i;
               reg_write_q  <= bus.RegWrite_i && bus.id_valid_i;
               mem_to_reg_q <= bus.MemToReg_i && bus.id_valid_i;
               mem_read_q   <= bus.MemRead_i  && bus.id_valid_i;
               mem_write_q  <= bus.MemWrite_i && bus.id_valid_i;
               branch_q     <= bus.Branch_i   && bus.id_valid_i;
               alu_src_q    <= bus.ALUSrc_i   && bus.id_valid_i;
               alu_op_q     <= bus.id_valid_i ? bus.ALUOp_i : ALU_OP_ADD;
            end
            UPD_FLUSH, UPD_BUBBLE: begin
               ex_valid_q   <= 1'b0;
               reg_write_q  <= 1'b0;
               mem_to_reg_q <= 1'b0;
               mem_read_q   <= 1'b0;
               mem_write_q  <= 1'b0;
               branch_q     <= 1'b0;
               alu_src_q    <= 1'b0;
               alu_op_q     <= ALU_OP_ADD;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bubble_cnt_q <= '0;
      else if (upd == UPD_BUBBLE && bubble_cnt_q != '1)
         bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
   end

   assign bus.ex_valid_o    = ex_valid_q;
   assign bus.ex_pc_o       = pc_q;
   assign bus.ex_rs1_data_o = rs1_data_q;
   assign bus.ex_rs2_data_o = rs2_data_q;
   assign bus.ex_imm_o      = imm_q;
   assign bus.ex_rs1_o      = rs1_q;
   assign bus.ex_rs2_o      = rs2_q;
   assign bus.ex_rd_o       = rd_q;
   assign bus.ex_funct3_o   = funct3_q;
   assign bus.ex_RegWrite_o = reg_write_q;
   assign bus.ex_MemToReg_o = mem_to_reg_q;
   assign bus.ex_MemRead_o  = mem_read_q;
   assign bus.ex_MemWrite_o = mem_write_q;
   assign bus.ex_Branch_o   = branch_q;
   assign bus.ex_ALUSrc_o   = alu_src_q;
   assign bus.ex_ALUOp_o    = alu_op_q;
   assign bus.bubble_cnt_o  = bubble_cnt_q;
endmodule
